// File: rtl/mult_karatsuba_pipe.sv
// Fully pipelined single-level Karatsuba multiplier with valid/tag sideband.
// Define KARATSUBA_SIGNED_EN to add the sgn port and the two's complement operand mode.
module mult_karatsuba_pipe #(
  parameter int WID    = 44,
  parameter int SUBLAT = 6,
  parameter int TAGW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              ld,
  input  logic [WID-1:0]    a,
  input  logic [WID-1:0]    b,
  input  logic [TAGW-1:0]   tag_i,
`ifdef KARATSUBA_SIGNED_EN
  input  logic              sgn,
`endif
  output logic [2*WID-1:0]  o,
  output logic              vo,
  output logic [TAGW-1:0]   tag_o
);

  localparam int H = WID / 2;
`ifdef KARATSUBA_SIGNED_EN
  localparam int LAT = SUBLAT + 7;
`else
  localparam int LAT = SUBLAT + 5;
`endif

  function automatic logic [H-1:0] mag_h(input logic [H:0] d);
    mag_h = d[H] ? (~d[H-1:0] + {{(H-1){1'b0}}, 1'b1}) : d[H-1:0];
  endfunction

  logic [WID-1:0]    core_a_s;
  logic [WID-1:0]    core_b_s;
  logic [H-1:0]      x1_s, x0_s, y1_s, y0_s;
  logic [H:0]        da_r, db_r;
  logic [H-1:0]      ma_r, mb_r;
  logic [SUBLAT:0]   s_r;
  logic [WID-1:0]    p3_r [SUBLAT];
  logic [WID-1:0]    z2_r [SUBLAT+2];
  logic [WID-1:0]    z0_r [SUBLAT+2];
  logic [WID:0]      p3_neg_s;
  logic [WID:0]      p4_r;
  logic [WID:0]      z1_r;
  logic [WID-1:0]    z2p_r, z0p_r, z2q_r, z0q_r;
  logic [2*WID-1:0]  core_sum_s;
  logic [2*WID-1:0]  final_s;
  logic [LAT-2:0]    v_r;
  logic [TAGW-1:0]   tag_r [LAT-1];

`ifdef KARATSUBA_SIGNED_EN
  function automatic logic [WID-1:0] mag_w(input logic [WID-1:0] v, input logic en);
    mag_w = (en && v[WID-1]) ? (~v + {{(WID-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [WID-1:0]    abs_a_r, abs_b_r;
  logic              nsg_in_s;
  logic [LAT-2:0]    nsg_r;
  logic [2*WID-1:0]  prod_r;

  assign nsg_in_s = sgn & (a[WID-1] ^ b[WID-1]);

  // Operand magnitude stage; -2^(WID-1) maps to 2^(WID-1) in the unsigned field
  always_ff @(posedge clk) begin
    if (ce) begin
      abs_a_r <= mag_w(a, sgn);
      abs_b_r <= mag_w(b, sgn);
    end
  end

  // Sign of the final product, carried alongside the valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      nsg_r <= {(LAT-1){1'b0}};
    end else if (ce) begin
      nsg_r <= {nsg_r[LAT-3:0], nsg_in_s};
    end
  end

  // Unsigned product register ahead of the sign-restore stage
  always_ff @(posedge clk) begin
    if (ce) begin
      prod_r <= core_sum_s;
    end
  end

  // Sign restore of the unsigned product
  always_comb begin
    final_s = prod_r;
    if (nsg_r[LAT-2]) begin
      final_s = {(2*WID){1'b0}} - prod_r;
    end else begin
      final_s = prod_r;
    end
  end

  assign core_a_s = abs_a_r;
  assign core_b_s = abs_b_r;
`else
  assign core_a_s = a;
  assign core_b_s = b;
  assign final_s  = core_sum_s;
`endif

  assign x1_s = core_a_s[WID-1:H];
  assign x0_s = core_a_s[H-1:0];
  assign y1_s = core_b_s[WID-1:H];
  assign y0_s = core_b_s[H-1:0];

  assign p3_neg_s   = {(WID+1){1'b0}} - {1'b0, p3_r[SUBLAT-1]};
  assign core_sum_s = {z2q_r, z0q_r} + ({{(WID-1){1'b0}}, z1_r} << H);

  // Karatsuba datapath: differences, magnitudes, three sub-products, cross-term recombination
  always_ff @(posedge clk) begin
    if (ce) begin
      da_r    <= {1'b0, x0_s} - {1'b0, x1_s};
      db_r    <= {1'b0, y1_s} - {1'b0, y0_s};
      ma_r    <= mag_h(da_r);
      mb_r    <= mag_h(db_r);
      s_r     <= {s_r[SUBLAT-1:0], da_r[H] ^ db_r[H]};
      p3_r[0] <= {{H{1'b0}}, ma_r} * {{H{1'b0}}, mb_r};
      z2_r[0] <= {{H{1'b0}}, x1_s} * {{H{1'b0}}, y1_s};
      z0_r[0] <= {{H{1'b0}}, x0_s} * {{H{1'b0}}, y0_s};
      for (int k = 1; k < SUBLAT; k++) begin
        p3_r[k] <= p3_r[k-1];
      end
      // z2/z0 run two stages longer so they meet p3 at the same edge
      for (int k = 1; k < SUBLAT + 2; k++) begin
        z2_r[k] <= z2_r[k-1];
        z0_r[k] <= z0_r[k-1];
      end
      if (s_r[SUBLAT]) begin
        p4_r <= p3_neg_s;
      end else begin
        p4_r <= {1'b0, p3_r[SUBLAT-1]};
      end
      z2p_r <= z2_r[SUBLAT+1];
      z0p_r <= z0_r[SUBLAT+1];
      z1_r  <= p4_r + {1'b0, z2p_r} + {1'b0, z0p_r};
      z2q_r <= z2p_r;
      z0q_r <= z0p_r;
    end
  end

  // Valid and tag shift register; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= {(LAT-1){1'b0}};
      for (int k = 0; k < LAT - 1; k++) begin
        tag_r[k] <= {TAGW{1'b0}};
      end
    end else if (ce) begin
      v_r      <= {v_r[LAT-3:0], ld};
      tag_r[0] <= tag_i;
      for (int k = 1; k < LAT - 1; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  // Output register; o/tag_o only move when a valid result arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      o     <= {(2*WID){1'b0}};
      vo    <= 1'b0;
      tag_o <= {TAGW{1'b0}};
    end else if (ce) begin
      vo <= v_r[LAT-2];
      if (v_r[LAT-2]) begin
        o     <= final_s;
        tag_o <= tag_r[LAT-2];
      end
    end
  end

endmodule
